// File: rtl/munch_pkg.sv
// munch_pkg: shared definitions for the munching-squares video engine.
//   - mode_e       : pattern select encoding (XOR / AND / ADD / XOR band)
//   - PALETTE      : 8-entry {R,G,B} colour table, 1 bit per channel,
//                    used only when MUNCH_PALETTE_EN is defined
//   - total_count(): sums the four segments of a raster axis
package munch_pkg;

    typedef enum logic [1:0] {
        MODE_XOR  = 2'd0,
        MODE_AND  = 2'd1,
        MODE_ADD  = 2'd2,
        MODE_BAND = 2'd3
    } mode_e;

    // Index 0 is the rightmost entry. Every entry is non-black so a lit pixel
    // is always distinguishable from an unlit one.
    localparam logic [7:0][2:0] PALETTE = {
        3'b111, 3'b101, 3'b001, 3'b011,   // 7..4: white, magenta, blue, cyan
        3'b010, 3'b110, 3'b100, 3'b111    // 3..0: green, yellow, red, white
    };

    function automatic int total_count(input int active, input int fp,
                                       input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/munch_raster_timing.sv
// munch_raster_timing: free-running h/v raster counters and their decode.
// Ports:
//   clk_i, rst_n_i      pixel clock, async active-low reset
//   ena_i               low holds both counters
//   h_cnt_o, v_cnt_o    current raster position
//   vis_o               position is inside the visible window
//   hsync_o, vsync_o    active-low sync decode of the current position
//   frame_start_o       position is (0,0)
//   frame_end_o         position is the last clock of the frame
// All outputs are combinational from the counter registers; the core
// registers them so everything leaves the engine with the same latency.
module munch_raster_timing
    import munch_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    localparam int H_TOTAL = total_count(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int V_TOTAL = total_count(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ena_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          vis_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_start_o,
    output logic          frame_end_o
);

    // Decode bounds compared at 32 bits so an edge that equals 2^HW
    // (zero back porch) does not truncate to zero.
    localparam logic [31:0] HS_LO = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_HI = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_LO = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_HI = 32'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_last, v_last;

    always_comb begin
        h_last = (h_q == HW'(H_TOTAL - 1));
        v_last = (v_q == VW'(V_TOTAL - 1));
        h_d    = h_q;
        v_d    = v_q;
        if (ena_i) begin
            h_d = h_last ? '0 : h_q + 1'b1;
            if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_cnt_o       = h_q;
    assign v_cnt_o       = v_q;
    assign vis_o         = (32'(h_q) < 32'(H_ACTIVE)) && (32'(v_q) < 32'(V_ACTIVE));
    assign hsync_o       = !((32'(h_q) >= HS_LO) && (32'(h_q) < HS_HI));
    assign vsync_o       = !((32'(v_q) >= VS_LO) && (32'(v_q) < VS_HI));
    assign frame_start_o = (h_q == '0) && (v_q == '0);
    assign frame_end_o   = h_last && v_last;

endmodule

// File: rtl/munch_vga_core.sv
// munch_vga_core: munching-squares pattern generator with VGA-style timing.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   ena               low freezes counters, t and latched mode; outputs blank
//   mode[1:0]         pattern select (see munch_pkg::mode_e)
//   speed[2:0]        t step per frame minus one
//   hsync, vsync      active-low syncs
//   de                visible pixel
//   rgb               {R,G,B}, COLOR_BITS per channel
//   frame_tick        one-clock pulse aligned with pixel (0,0)
// Optional: define MUNCH_PALETTE_EN to colour lit pixels from munch_pkg::PALETTE
// instead of plain white.
// Every output is a register loaded from the counter position, so output for
// raster (h,v) appears one clock after the counters hold (h,v).
module munch_vga_core
    import munch_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int COLOR_BITS = 2,
    parameter int T_BITS     = 8,
    parameter int SHIFT      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [1:0]              mode,
    input  logic [2:0]              speed,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    de,
    output logic [3*COLOR_BITS-1:0] rgb,
    output logic                    frame_tick
);

    localparam int HW = $clog2(total_count(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int VW = $clog2(total_count(V_ACTIVE, V_FP, V_SYNC, V_BP));

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          vis, hs_n, vs_n, frame_start, frame_end;

    munch_raster_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .ena_i         (ena),
        .h_cnt_o       (h_cnt),
        .v_cnt_o       (v_cnt),
        .vis_o         (vis),
        .hsync_o       (hs_n),
        .vsync_o       (vs_n),
        .frame_start_o (frame_start),
        .frame_end_o   (frame_end)
    );

    mode_e                   mode_q, mode_d, mode_sel;
    logic [2:0]              speed_q, speed_d;
    logic [T_BITS-1:0]       t_q, t_d;
    logic [T_BITS-1:0]       x, y, pv;
    logic                    lit;
    logic [3*COLOR_BITS-1:0] pix;
    logic                    hsync_q, vsync_q, de_q, tick_q;
    logic                    hsync_d, vsync_d, de_d, tick_d;
    logic [3*COLOR_BITS-1:0] rgb_q, rgb_d;

    // Pixel (0,0) is computed on the same edge that latches mode, so it takes
    // the incoming mode directly; the whole frame then uses one mode.
    // t advances on the last clock of a frame, so t_q is already the new
    // frame's value when the raster reaches (0,0).
    always_comb begin
        mode_sel = frame_start ? mode_e'(mode) : mode_q;
        x        = T_BITS'(h_cnt >> SHIFT);
        y        = T_BITS'(v_cnt >> SHIFT);
        pv       = x ^ y;
        case (mode_sel)
            MODE_AND: pv = x & y;
            MODE_ADD: pv = x + y;
            default:  pv = x ^ y;
        endcase
        lit = (mode_sel == MODE_BAND) ? (t_q[T_BITS-1:2] == pv[T_BITS-1:2])
                                      : (pv < t_q);
    end

`ifdef MUNCH_PALETTE_EN
    logic [2:0] pal_idx, pal_rgb;
    assign pal_idx = t_q[T_BITS-1 -: 3] + pv[2:0];
    assign pal_rgb = PALETTE[pal_idx];
    assign pix     = lit ? {{COLOR_BITS{pal_rgb[2]}}, {COLOR_BITS{pal_rgb[1]}},
                            {COLOR_BITS{pal_rgb[0]}}} : '0;
`else
    assign pix     = {(3*COLOR_BITS){lit}};
`endif

    always_comb begin
        mode_d  = mode_q;
        speed_d = speed_q;
        t_d     = t_q;
        hsync_d = 1'b1;
        vsync_d = 1'b1;
        de_d    = 1'b0;
        rgb_d   = '0;
        tick_d  = 1'b0;
        if (ena) begin
            if (frame_start) begin
                mode_d  = mode_e'(mode);
                speed_d = speed;
            end
            if (frame_end) t_d = t_q + T_BITS'(speed_q) + T_BITS'(1);
            hsync_d = hs_n;
            vsync_d = vs_n;
            de_d    = vis;
            rgb_d   = vis ? pix : '0;
            tick_d  = frame_start;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_XOR;
            speed_q <= '0;
            t_q     <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            speed_q <= speed_d;
            t_q     <= t_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            rgb_q   <= rgb_d;
            tick_q  <= tick_d;
        end
    end

    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign de         = de_q;
    assign rgb        = rgb_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_munch_vga_core.sv
// Bench for munch_vga_core with a small 12x7 raster (8/1/2/1, 4/1/1/1).
// A frame-level model tracks position within the frame, the per-frame t and
// the mode/speed seen at the start of each frame, and predicts every output.
module tb_munch_vga_core;
    localparam int HT = 12, VT = 7, FR = HT * VT;

    logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] speed = 3'd0;
    logic       hsync, vsync, de, frame_tick;
    logic [5:0] rgb;

    int n_tests = 0, n_fail = 0;

    int m_pos, m_t, m_mode, m_speed, m_frame;
    int e_h, e_v;
    logic e_hs, e_vs, e_de, e_tick;
    logic [5:0] e_rgb;

`ifdef MUNCH_PALETTE_EN
    localparam logic [2:0] PAL [8] = '{3'b111, 3'b100, 3'b110, 3'b010,
                                       3'b011, 3'b001, 3'b101, 3'b111};
`endif

    always #5 clk = ~clk;

    munch_vga_core #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .COLOR_BITS(2), .T_BITS(8), .SHIFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode), .speed(speed),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_tick(frame_tick)
    );

    function automatic logic [5:0] exp_color(input int h, input int v, input int md, input int t);
        int val;
        bit lit;
`ifdef MUNCH_PALETTE_EN
        logic [2:0] c;
`endif
        case (md)
            1:       val = h & v;
            2:       val = (h + v) % 256;
            default: val = h ^ v;
        endcase
        lit = (md == 3) ? ((t >> 2) == (val >> 2)) : (val < t);
        if (h >= 8 || v >= 4 || !lit) return 6'h00;
`ifdef MUNCH_PALETTE_EN
        c = PAL[((t >> 5) + val) % 8];
        return {{2{c[2]}}, {2{c[1]}}, {2{c[0]}}};
`else
        return 6'h3f;
`endif
    endfunction

    // Advance one clock and update the model's prediction for the outputs
    // registered at that edge.
    task automatic clk_step();
        @(posedge clk);
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_tick = 1'b0; e_rgb = 6'h00;
        if (!rst_n) begin
            m_pos = 0; m_t = 0; m_mode = 0; m_speed = 0; m_frame = -1;
        end else if (ena) begin
            e_h = m_pos % HT;
            e_v = m_pos / HT;
            if (m_pos == 0) begin
                m_mode = int'(mode); m_speed = int'(speed); m_frame++;
            end
            e_hs   = !(e_h >= 9 && e_h < 11);
            e_vs   = !(e_v == 5);
            e_de   = (e_h < 8) && (e_v < 4);
            e_tick = (m_pos == 0);
            e_rgb  = exp_color(e_h, e_v, m_mode, m_t);
            if (m_pos == FR - 1) m_t = (m_t + m_speed + 1) % 256;
            m_pos = (m_pos + 1) % FR;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clk_step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_tick(input int budget);
        int n = 0;
        do begin clk_step(); n++; end while (frame_tick !== 1'b1 && n < budget);
        n_tests++;
        if (frame_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL tick_timeout: no frame_tick within %0d clocks", budget);
        end
    endtask

    task automatic test_reset();
        int cnt;
        ena = 1'b1; mode = 2'd0; speed = 3'd0; rst_n = 1'b0;
        repeat (3) clk_step();
        n_tests++;
        if ({hsync, vsync, de, frame_tick, rgb} !== 10'b1100_000000) begin
            n_fail++;
            $display("FAIL reset_blank: got %b want 1100000000", {hsync, vsync, de, frame_tick, rgb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        clk_step();
        n_tests++;
        if (frame_tick !== 1'b1) begin
            n_fail++; $display("FAIL first_tick: got %b want 1", frame_tick);
        end
        cnt = 0;
        do begin
            clk_step(); cnt++;
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_reset (h=%0d v=%0d): got %b want %b", e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
        end while (frame_tick !== 1'b1 && cnt < 200);
        n_tests++;
        if (cnt != FR) begin
            n_fail++; $display("FAIL frame_period: got %0d want %0d", cnt, FR);
        end
        // Stop on a visible pixel, then assert reset between edges.
        repeat (3) clk_step();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({hsync, vsync, de, frame_tick, rgb} !== 10'b1100_000000) begin
            n_fail++;
            $display("FAIL async_clear: got %b want 1100000000", {hsync, vsync, de, frame_tick, rgb});
        end
        clk_step();
        @(negedge clk);
        rst_n = 1'b1;
        clk_step();
        n_tests++;
        if (frame_tick !== 1'b1) begin
            n_fail++; $display("FAIL restart_tick: got %b want 1", frame_tick);
        end
    endtask

    task automatic test_sync();
        int hs_first = -1, hs_line0 = 0, vs_first = -1, vs_cnt = 0;
        do_reset();
        clk_step();
        for (int off = 1; off < FR; off++) begin
            clk_step();
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_sync (h=%0d v=%0d): got %b want %b", e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
            if (hsync === 1'b0 && hs_first < 0) hs_first = off;
            if (hsync === 1'b0 && off < HT) hs_line0++;
            if (vsync === 1'b0 && vs_first < 0) vs_first = off;
            if (vsync === 1'b0) vs_cnt++;
        end
        n_tests++;
        if (hs_first != 9 || hs_line0 != 2) begin
            n_fail++; $display("FAIL hsync_timing: got start %0d width %0d want 9 2", hs_first, hs_line0);
        end
        n_tests++;
        if (vs_first != 5 * HT || vs_cnt != HT) begin
            n_fail++; $display("FAIL vsync_timing: got start %0d width %0d want 60 12", vs_first, vs_cnt);
        end
    endtask

    task automatic test_xor();
        int lit0 = 0, de3 = 0;
        mode = 2'd0; speed = 3'd0;
        do_reset();
        for (int i = 0; i < 4 * FR; i++) begin
            clk_step();
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_xor (f=%0d h=%0d v=%0d): got %b want %b", m_frame, e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
            if (m_frame == 0 && rgb !== 6'h00) lit0++;
            if (m_frame == 3 && de === 1'b1) de3++;
            if (m_frame == 3 && e_h == 1 && e_v == 2) begin
                n_tests++;
                if (rgb !== 6'h00) begin n_fail++; $display("FAIL xor_dark_1_2: got %h want 00", rgb); end
            end
            if (m_frame == 3 && e_h == 1 && e_v == 1) begin
                n_tests++;
                if (rgb === 6'h00) begin n_fail++; $display("FAIL xor_lit_1_1: got %h want nonzero", rgb); end
            end
        end
        n_tests++;
        if (lit0 != 0) begin n_fail++; $display("FAIL frame0_dark: got %0d lit want 0", lit0); end
        n_tests++;
        if (de3 != 32) begin n_fail++; $display("FAIL de_count: got %0d want 32", de3); end
    endtask

    task automatic test_tear_free();
        mode = 2'd0; speed = 3'd0;
        do_reset();
        for (int i = 0; i < 4 * FR; i++) begin
            clk_step();
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_tear (f=%0d h=%0d v=%0d): got %b want %b", m_frame, e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
            if (m_frame == 2 && e_h == 6 && e_v == 2) mode = 2'd1;
            if (m_frame == 2 && e_h == 3 && e_v == 3) begin
                n_tests++;
                if (rgb === 6'h00) begin n_fail++; $display("FAIL tear_still_xor: got %h want nonzero", rgb); end
            end
            if (m_frame == 3 && e_h == 3 && e_v == 3) begin
                n_tests++;
                if (rgb !== 6'h00) begin n_fail++; $display("FAIL tear_and_3_3: got %h want 00", rgb); end
            end
            if (m_frame == 3 && e_h == 1 && e_v == 2) begin
                n_tests++;
                if (rgb === 6'h00) begin n_fail++; $display("FAIL tear_and_1_2: got %h want nonzero", rgb); end
            end
        end
    endtask

    task automatic test_speed_wrap();
        int lit31 = 0, lit32 = 0;
        mode = 2'd0; speed = 3'd7;
        do_reset();
        for (int i = 0; i < 33 * FR; i++) begin
            clk_step();
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_speed (f=%0d h=%0d v=%0d): got %b want %b", m_frame, e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
            if (m_frame == 31 && rgb !== 6'h00) lit31++;
            if (m_frame == 32 && rgb !== 6'h00) lit32++;
        end
        n_tests++;
        if (lit31 != 32) begin n_fail++; $display("FAIL t248_all_lit: got %0d want 32", lit31); end
        n_tests++;
        if (lit32 != 0) begin n_fail++; $display("FAIL t_wrap_dark: got %0d want 0", lit32); end
    endtask

    task automatic test_ena_hold();
        int cnt = 0;
        mode = 2'd0; speed = 3'd0;
        do_reset();
        clk_step();
        wait_tick(2 * FR);
        repeat (8) begin clk_step(); cnt++; end
        ena = 1'b0;
        repeat (20) begin
            clk_step(); cnt++;
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== 10'b1100_000000) begin
                n_fail++;
                $display("FAIL ena_blank: got %b want 1100000000", {hsync, vsync, de, frame_tick, rgb});
            end
        end
        ena = 1'b1;
        clk_step(); cnt++;
        n_tests++;
        if (hsync !== 1'b0) begin n_fail++; $display("FAIL ena_resume_pos: hsync got %b want 0", hsync); end
        do begin
            clk_step(); cnt++;
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_ena (h=%0d v=%0d): got %b want %b", e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
        end while (frame_tick !== 1'b1 && cnt < 300);
        n_tests++;
        if (cnt != FR + 20) begin n_fail++; $display("FAIL ena_period: got %0d want %0d", cnt, FR + 20); end
    endtask

    task automatic test_random();
        mode = 2'($urandom_range(3)); speed = 3'($urandom_range(7)); ena = 1'b1;
        do_reset();
        for (int i = 0; i < 2500; i++) begin
            clk_step();
            n_tests++;
            if ({hsync, vsync, de, frame_tick, rgb} !== {e_hs, e_vs, e_de, e_tick, e_rgb}) begin
                n_fail++;
                $display("FAIL model_random (f=%0d h=%0d v=%0d): got %b want %b", m_frame, e_h, e_v,
                         {hsync, vsync, de, frame_tick, rgb}, {e_hs, e_vs, e_de, e_tick, e_rgb});
            end
            if ($urandom_range(40) == 0) mode = 2'($urandom_range(3));
            if ($urandom_range(60) == 0) speed = 3'($urandom_range(7));
            if ($urandom_range(ena ? 25 : 4) == 0) ena = ~ena;
        end
        ena = 1'b1;
    endtask

`ifdef MUNCH_PALETTE_EN
    task automatic test_palette();
        mode = 2'd0; speed = 3'd7;
        do_reset();
        for (int i = 0; i < 5 * FR; i++) begin
            clk_step();
            if (m_frame == 4 && e_h == 1 && e_v == 0) begin
                n_tests++;
                if (rgb !== 6'b111100) begin n_fail++; $display("FAIL palette_entry2: got %b want 111100", rgb); end
            end
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sync();
        test_xor();
        test_tear_free();
        test_speed_wrap();
        test_ena_hold();
        test_random();
`ifdef MUNCH_PALETTE_EN
        test_palette();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
